q_dot_mac: RTL
==============

Q_DOT_MAC -- requirements
Module: q_dot_mac

Interface
REQ-001 Parameter WIDTH, default 32, word width of operands and result.
REQ-002 Parameter FRAC, default 19, fractional bits (Q(WIDTH-FRAC).FRAC, two's complement).
REQ-003 Parameter ADDR_W, default 10, memory address width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request to compute one dot product; sampled only when busy=0.
REQ-007 len  input  ADDR_W  number of terms, sampled with accepted start.
REQ-008 base_a, base_b  input  ADDR_W each  first addresses of vector A / B, sampled with accepted start.
REQ-009 a_addr, b_addr  output  ADDR_W each  read addresses to two single-port ROMs with 1-cycle registered read latency.
REQ-010 rd_en  output  1  high on cycles in which a_addr/b_addr carry a valid term address.
REQ-011 a_data, b_data  input  WIDTH each  ROM read data, valid the cycle after the address.
REQ-012 busy  output  1  high from the cycle after accepted start until done.
REQ-013 done  output  1  single-cycle pulse; result valid.
REQ-014 result  output  WIDTH  accumulated sum; held until next accepted start.
REQ-015 ovf  output  1  sticky saturation flag for the current operation.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with len>0; IDLE->DONE on start with len=0; RUN->DRAIN after last address issued; DRAIN->DONE after 3 cycles; DONE->IDLE unconditionally.
REQ-017 Accepted start (cycle 0) clears accumulator, result and ovf to 0 at that edge.
REQ-018 In RUN, term k (0..len-1) issues a_addr=base_a+k, b_addr=base_b+k, rd_en=1 in cycle k+1; one term per clock, no bubbles.
REQ-019 Address addition wraps modulo 2^ADDR_W.
REQ-020 Pipeline: address (k+1) -> data (k+2) -> registered product (k+3) -> accumulator update at end of cycle k+3.
REQ-021 Product = full 2*WIDTH signed product arithmetically shifted right by FRAC (truncation toward minus infinity), saturated to WIDTH-bit signed range.
REQ-022 Accumulate = signed add saturated to [-(2^(WIDTH-1)), 2^(WIDTH-1)-1]; saturated accumulator continues accumulating from the clamped value.
REQ-023 Any product or accumulate saturation sets ovf, which stays set until next accepted start or reset.
REQ-024 done=1 exactly in cycle len+4 for len>0, cycle 1 for len=0 (result 0); result updated in the same cycle done rises.
REQ-025 start while busy=1 or done=1 is ignored; no effect on state, len or bases.
REQ-026 start in the IDLE cycle following done is accepted (back-to-back operation, no dead cycle beyond DONE).
REQ-027 rd_en=0 and addresses hold last value outside RUN.
REQ-028 len sampled once; changes to len/base_* during busy have no effect.

Reset
REQ-029 rst=1 at any edge forces IDLE, busy=0, done=0, rd_en=0, result=0, ovf=0, accumulator and pipeline registers=0, a_addr=b_addr=0.
REQ-030 rst has priority over start in the same cycle; an operation interrupted by reset produces no done pulse.

Verification
REQ-031 WIDTH=32, FRAC=19: len=3, A={0x00080000(1.0), 0x00100000(2.0), 0xFFFC0000(-0.5)}, B={0x00100000, 0x00040000, 0x00200000} -> done at cycle 7, result=0x00080000 (1.0), ovf=0.
REQ-032 len=0 start -> done at cycle 1, result=0, rd_en never asserted, busy never asserted.
REQ-033 len=4, all A=B=0x7FFFFFFF -> each product saturates, result=0x7FFFFFFF, ovf=1; next start with small values clears ovf.
REQ-034 start pulsed at cycles 0 and 2 with len=5 -> only first accepted, single done at cycle 9; start in cycle 10 accepted.
REQ-035 rst asserted at cycle 3 of len=8 run -> cycle 4 busy=0, result=0, rd_en=0, no done thereafter.
REQ-036 base_a=0x3FE, len=4, ADDR_W=10 -> a_addr sequence 0x3FE, 0x3FF, 0x000, 0x001 in cycles 1-4.

Source files
------------

// File: rtl/q_dot_mac_if.sv
// Bus bundle for q_dot_mac: start/operand handshake, ROM read port and result/status.
interface q_dot_mac_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              rd_en;
    logic [WIDTH-1:0]  a_data;
    logic [WIDTH-1:0]  b_data;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  result;
    logic              ovf;

    modport slave (
        input  start, len, base_a, base_b, a_data, b_data,
        output a_addr, b_addr, rd_en, busy, done, result, ovf
    );

    modport master (
        output start, len, base_a, base_b, a_data, b_data,
        input  a_addr, b_addr, rd_en, busy, done, result, ovf
    );
endinterface

// File: rtl/q_dot_mac.sv
// Fixed-point saturating dot-product engine reading two vectors from 1-cycle-latency ROMs.
module q_dot_mac #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 19,
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    q_dot_mac_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] remain_q;
    logic [1:0]        drain_q;
    logic [ADDR_W-1:0] a_addr_q, b_addr_q;
    logic              dv_q, pv_q;
    logic [WIDTH-1:0]  prod_q, acc_q, result_q;
    logic              ovf_q;

    logic                      accept;
    logic                      rd_en;
    logic signed [2*WIDTH-1:0] full_prod, shifted;
    logic [WIDTH:0]            hi_bits;
    logic                      prod_ovf;
    logic [WIDTH-1:0]          prod_sat;
    logic [WIDTH:0]            acc_sum;
    logic                      acc_ovf;
    logic [WIDTH-1:0]          acc_next;

    assign accept = (state_q == IDLE) && bus.start;
    assign rd_en  = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = (bus.len != '0) ? RUN : DONE;
            RUN:     if (remain_q == '0) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'd2) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Full-width product, then arithmetic shift floors toward minus infinity before clamping.
    always_comb begin
        full_prod = $signed({{WIDTH{bus.a_data[WIDTH-1]}}, bus.a_data})
                  * $signed({{WIDTH{bus.b_data[WIDTH-1]}}, bus.b_data});
        shifted   = full_prod >>> FRAC;
        hi_bits   = shifted[2*WIDTH-1:WIDTH-1];
        prod_ovf  = !((&hi_bits) || !(|hi_bits));
        prod_sat  = prod_ovf ? (shifted[2*WIDTH-1] ? SMIN : SMAX) : shifted[WIDTH-1:0];
        acc_sum   = {acc_q[WIDTH-1], acc_q} + {prod_q[WIDTH-1], prod_q};
        acc_ovf   = acc_sum[WIDTH] ^ acc_sum[WIDTH-1];
        acc_next  = acc_ovf ? (acc_sum[WIDTH] ? SMIN : SMAX) : acc_sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            drain_q  <= '0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            dv_q     <= 1'b0;
            pv_q     <= 1'b0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;

            if (state_q == RUN && remain_q != '0) begin
                a_addr_q <= a_addr_q + ADDR_W'(1);
                b_addr_q <= b_addr_q + ADDR_W'(1);
                remain_q <= remain_q - ADDR_W'(1);
            end

            dv_q <= rd_en;
            pv_q <= dv_q;
            if (dv_q) begin
                prod_q <= prod_sat;
                if (prod_ovf) ovf_q <= 1'b1;
            end
            if (pv_q) begin
                acc_q <= acc_next;
                if (acc_ovf) ovf_q <= 1'b1;
            end

            if (state_q == DRAIN && state_d == DONE) result_q <= acc_q;

            // Pipeline is empty whenever a start can be accepted, so clearing here never races it.
            if (accept) begin
                acc_q    <= '0;
                result_q <= '0;
                ovf_q    <= 1'b0;
                remain_q <= bus.len - ADDR_W'(1);
                if (bus.len != '0) begin
                    a_addr_q <= bus.base_a;
                    b_addr_q <= bus.base_b;
                end
            end
        end
    end

    assign bus.a_addr = a_addr_q;
    assign bus.b_addr = b_addr_q;
    assign bus.rd_en  = rd_en;
    assign bus.busy   = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
endmodule
